// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader and the instruction memory.
// Optional feature macro: INSTRUCTION_LOADER_CHECKSUM_EN (trailing XOR byte).
package instruction_loader_pkg;

    typedef enum logic [2:0] {
        HDR0  = 3'd0,
        HDR1  = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        CSUM  = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } loader_state_t;

    localparam int HDR_BYTES = 2;

    // Byte-address width of an instruction memory of word_count words.
    function automatic int calc_addr_bits(input int word_count, input int word_bits);
        return $clog2(word_count * (word_bits / 8));
    endfunction

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// Little-endian byte-to-word assembler: places each accepted byte into the
// next lane and flags the byte that completes a word.
module loader_word_assembler #(
    parameter int WORD_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 shift_en,
    input  logic [7:0]           byte_in,
    output logic [WORD_BITS-1:0] word_next,
    output logic                 word_complete
);

    localparam int BYTES    = WORD_BITS / 8;
    localparam int IDX_BITS = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(BYTES - 1);

    logic [IDX_BITS-1:0]  byte_idx;
    logic [WORD_BITS-1:0] word_q;

    // Current partial word with the incoming byte dropped into its lane.
    always_comb begin
        word_next = word_q;
        for (int i = 0; i < BYTES; i++) begin
            if (byte_idx == IDX_BITS'(i)) begin
                word_next[8*i +: 8] = byte_in;
            end
        end
    end

    assign word_complete = shift_en && (byte_idx == LAST_IDX);

    // Lane counter and partial-word storage; flush realigns to lane 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx <= '0;
            word_q   <= '0;
        end else if (flush) begin
            byte_idx <= '0;
        end else if (shift_en) begin
            word_q   <= word_next;
            byte_idx <= word_complete ? '0 : byte_idx + 1'b1;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Framed byte-stream loader for the GPU instruction memory. Assembles
// little-endian words, writes them at word-aligned byte addresses and holds
// the core off while an image is loading.
// Optional feature macro: INSTRUCTION_LOADER_CHECKSUM_EN -- when defined the
// frame ends with an XOR-of-all-bytes checksum byte checked in CSUM.
//
// state | meaning
// HDR0  | idle, waiting for word count low byte
// HDR1  | waiting for word count high byte, range check
// DATA  | collecting payload bytes of the current word
// WRITE | one-cycle RAM write of the assembled word (bubble, not ready)
// CSUM  | waiting for trailing checksum byte (checksum build only)
// DONE  | one-cycle completion pulse, hold released
// ERROR | bad frame; stays until clear_i
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int WORD_COUNT = 64,
    parameter int WORD_BITS  = 32,
    localparam int BYTES_PER_WORD = WORD_BITS / 8,
    localparam int ADDR_BITS      = calc_addr_bits(WORD_COUNT, WORD_BITS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 byte_valid_i,
    input  logic [7:0]           byte_data_i,
    output logic                 byte_ready_o,
    input  logic                 clear_i,
    output logic                 wr_en_o,
    output logic [ADDR_BITS-1:0] wr_addr_o,
    output logic [WORD_BITS-1:0] wr_data_o,
    output logic                 cpu_hold_o,
    output logic                 done_o,
    output logic                 error_o
);

    localparam int IDX_BITS  = $clog2(WORD_COUNT) + 1;
    localparam int LANE_BITS = $clog2(BYTES_PER_WORD);
    localparam logic [15:0] MAX_WORDS = 16'(WORD_COUNT);

    loader_state_t         state_q, state_d;
    logic [7:0]            n_lo_q;
    logic [15:0]           n_words_q;
    logic [IDX_BITS-1:0]   word_idx_q;
    logic [ADDR_BITS-1:0]  wr_addr_q;
    logic [WORD_BITS-1:0]  wr_data_q;
    logic [15:0]           hdr_count;
    logic                  last_word;
    logic                  ready;
    logic                  xfer;
    logic                  hold;
    logic                  done;
    logic                  err;
    logic                  wr_en;
    logic [WORD_BITS-1:0]  word_next;
    logic                  word_complete;

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q;
    localparam loader_state_t END_STATE = CSUM;
`else
    localparam loader_state_t END_STATE = DONE;
`endif

    assign ready     = (state_q inside {HDR0, HDR1, DATA, CSUM});
    assign xfer      = byte_valid_i && ready;
    assign hdr_count = {byte_data_i, n_lo_q};
    assign last_word = ((16'(word_idx_q) + 16'd1) == n_words_q);

    loader_word_assembler #(
        .WORD_BITS (WORD_BITS)
    ) u_assembler (
        .clk           (clk_i),
        .rst_n         (rst_ni),
        .flush         (state_q != DATA),
        .shift_en      (xfer && (state_q == DATA)),
        .byte_in       (byte_data_i),
        .word_next     (word_next),
        .word_complete (word_complete)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= HDR0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state output decode.
    always_comb begin
        state_d = state_q;
        hold    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            HDR0: begin
                if (xfer) state_d = HDR1;
            end
            HDR1: begin
                hold = 1'b1;
                if (xfer) begin
                    if (hdr_count == 16'd0)          state_d = END_STATE;
                    else if (hdr_count > MAX_WORDS)  state_d = ERROR;
                    else                             state_d = DATA;
                end
            end
            DATA: begin
                hold = 1'b1;
                if (word_complete) state_d = WRITE;
            end
            WRITE: begin
                hold  = 1'b1;
                wr_en = 1'b1;
                state_d = last_word ? END_STATE : DATA;
            end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            CSUM: begin
                hold = 1'b1;
                if (xfer) state_d = (byte_data_i == csum_q) ? DONE : ERROR;
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_d = HDR0;
            end
            ERROR: begin
                hold = 1'b1;
                err  = 1'b1;
                if (clear_i) state_d = HDR0;
            end
            default: state_d = HDR0;
        endcase
    end

    // Header capture, word counter and write-port registers (held between writes).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            n_lo_q     <= '0;
            n_words_q  <= '0;
            word_idx_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            if (xfer && (state_q == HDR0)) begin
                n_lo_q <= byte_data_i;
            end
            if (xfer && (state_q == HDR1)) begin
                n_words_q  <= hdr_count;
                word_idx_q <= '0;
            end
            if (word_complete) begin
                wr_data_q <= word_next;
                wr_addr_q <= ADDR_BITS'(word_idx_q) << LANE_BITS;
            end
            if (state_q == WRITE) begin
                word_idx_q <= word_idx_q + 1'b1;
            end
        end
    end

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    // Running XOR over header and payload bytes; restarts on each new frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            csum_q <= '0;
        end else if (xfer) begin
            if (state_q == HDR0)       csum_q <= byte_data_i;
            else if (state_q != CSUM)  csum_q <= csum_q ^ byte_data_i;
        end
    end
`endif

    assign byte_ready_o = ready;
    assign wr_en_o      = wr_en;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign cpu_hold_o   = hold;
    assign done_o       = done;
    assign error_o      = err;

endmodule
